// File: rtl/zxmmc_spi_master_if.sv
// CPU-side port bundle for zxmmc_spi_master.
// The port decoder drives the strobes and write data through the master modport.
// The SPI engine returns read data and status through the slave modport.
interface zxmmc_spi_master_if #(
  parameter int unsigned NUM_CARDS = 2
);
  logic                 cs_wr;
  logic [NUM_CARDS-1:0] cs_din;
  logic                 tx_wr;
  logic [7:0]           tx_din;
  logic                 rx_rd;
  logic [7:0]           rx_data;
  logic                 busy;
  logic                 overrun;

  modport master (
    output cs_wr, cs_din, tx_wr, tx_din, rx_rd,
    input  rx_data, busy, overrun
  );

  modport slave (
    input  cs_wr, cs_din, tx_wr, tx_din, rx_rd,
    output rx_data, busy, overrun
  );
endinterface

// File: rtl/zxmmc_spi_master.sv
// SD/MMC SPI master (mode 0, MSB first).
// Includes a one-deep holding buffer so that back-to-back port accesses chain
// without an idle gap.
// Optional macro ZXMMC_SPI_DIVREG_EN adds a runtime half-period divider register.
// Writes to that register while busy are deferred until the block next goes idle.
module zxmmc_spi_master #(
  parameter int unsigned NUM_CARDS = 2,
  parameter int unsigned DIV_WIDTH = 4,
  parameter int unsigned CLK_DIV   = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  zxmmc_spi_master_if.slave    bus,
`ifdef ZXMMC_SPI_DIVREG_EN
  input  logic                 div_wr,
  input  logic [DIV_WIDTH-1:0] div_din,
`endif
  output logic [NUM_CARDS-1:0] card,
  output logic                 spi_clock,
  output logic                 spi_dataout,
  input  logic                 spi_datain
);

  localparam int unsigned EDGE_W    = 5;
  localparam int unsigned LAST_EDGE = 16;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [EDGE_W-1:0]     edge_cnt_q, edge_cnt_d;
  logic [7:0]            tx_sh_q, tx_sh_d;
  logic [7:0]            rx_sh_q, rx_sh_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic [7:0]            rx_data_q, rx_data_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;
  logic [NUM_CARDS-1:0]  card_q, card_d;
  logic                  hold_full_q, hold_full_d;
  logic [7:0]            hold_byte_q, hold_byte_d;

  logic                  start_c;
  logic [7:0]            start_byte_c;
  logic [EDGE_W-1:0]     edge_next_c;
  logic [DIV_WIDTH-1:0]  lim_c;
  logic                  tick_c;
  logic                  done_c;
  logic                  drain_c;
  logic                  direct_c;
  logic                  idle_c;
  logic                  load_c;
  logic [7:0]            load_byte_c;
  logic                  drop_c;

`ifdef ZXMMC_SPI_DIVREG_EN
  logic [DIV_WIDTH-1:0]  div_lim_q, div_lim_d;
  logic                  div_pend_q, div_pend_d;
  logic [DIV_WIDTH-1:0]  div_pend_val_q, div_pend_val_d;

  assign lim_c = div_lim_q;

  // Divider register: immediate load when idle, deferred to the next idle entry otherwise
  always_comb begin
    div_lim_d      = div_lim_q;
    div_pend_d     = div_pend_q;
    div_pend_val_d = div_pend_val_q;
    if (state_q == IDLE) begin
      if (div_wr) begin
        div_lim_d = div_din;
      end
    end else if (idle_c) begin
      div_pend_d = 1'b0;
      if (div_wr) begin
        div_lim_d = div_din;
      end else if (div_pend_q) begin
        div_lim_d = div_pend_val_q;
      end
    end else if (div_wr) begin
      div_pend_d     = 1'b1;
      div_pend_val_d = div_din;
    end
  end

  // Divider register state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_lim_q      <= DIV_WIDTH'(CLK_DIV);
      div_pend_q     <= 1'b0;
      div_pend_val_q <= '0;
    end else begin
      div_lim_q      <= div_lim_d;
      div_pend_q     <= div_pend_d;
      div_pend_val_q <= div_pend_val_d;
    end
  end
`else
  assign lim_c = DIV_WIDTH'(CLK_DIV);
`endif

  // Start-request decode and SPI timing events
  always_comb begin
    start_c      = bus.tx_wr | bus.rx_rd;
    start_byte_c = bus.tx_wr ? bus.tx_din : 8'hFF;
    edge_next_c  = edge_cnt_q + EDGE_W'(1);
    tick_c       = (state_q == SHIFT) && (div_cnt_q == lim_c);
    done_c       = tick_c && (edge_next_c == EDGE_W'(LAST_EDGE));
    drain_c      = done_c && hold_full_q;
    direct_c     = done_c && !hold_full_q && start_c;
    idle_c       = done_c && !hold_full_q && !start_c;
  end

  // Next-state logic: shifting, end-of-byte chaining, holding buffer, chip selects
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    rx_data_d   = rx_data_q;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    card_d      = card_q;
    hold_full_d = hold_full_q;
    hold_byte_d = hold_byte_q;
    load_c      = 1'b0;
    load_byte_c = start_byte_c;
    drop_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_c) begin
          load_c = 1'b1;
        end
      end
      SHIFT: begin
        if (tick_c) begin
          sclk_d     = ~sclk_q;
          div_cnt_d  = '0;
          edge_cnt_d = edge_next_c;
          if (edge_next_c[0]) begin
            rx_sh_d = {rx_sh_q[6:0], spi_datain};
          end else if (!done_c) begin
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
            mosi_d  = tx_sh_q[6];
          end
          if (done_c) begin
            rx_data_d  = rx_sh_q;
            edge_cnt_d = '0;
            if (hold_full_q) begin
              load_c      = 1'b1;
              load_byte_c = hold_byte_q;
              hold_full_d = 1'b0;
            end else if (start_c) begin
              load_c = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
              mosi_d  = 1'b1;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        end
        // A request arriving mid-byte is parked in the holding buffer if there is room
        if (start_c && !direct_c) begin
          if (!hold_full_q || drain_c) begin
            hold_byte_d = start_byte_c;
            hold_full_d = 1'b1;
          end else begin
            drop_c = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_c) begin
      state_d    = SHIFT;
      busy_d     = 1'b1;
      tx_sh_d    = load_byte_c;
      mosi_d     = load_byte_c[7];
      rx_sh_d    = '0;
      div_cnt_d  = '0;
      edge_cnt_d = '0;
    end

    if (bus.cs_wr) begin
      card_d    = bus.cs_din;
      overrun_d = 1'b0;
    end
    if (drop_c) begin
      overrun_d = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      edge_cnt_q  <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b1;
      rx_data_q   <= 8'hFF;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      card_q      <= '1;
      hold_full_q <= 1'b0;
      hold_byte_q <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      rx_data_q   <= rx_data_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      card_q      <= card_d;
      hold_full_q <= hold_full_d;
      hold_byte_q <= hold_byte_d;
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;
  assign card        = card_q;
  assign spi_clock   = sclk_q;
  assign spi_dataout = mosi_q;

endmodule
